lb_regfile: RTL and testbench

LB_REGFILE -- requirements
Module: lb_regfile

---
 rtl/lb_pkg.sv | 21 ++
 rtl/lb_rd_delay.sv | 80 ++++++++
 rtl/lb_regfile.sv | 130 +++++++++++++
 tb/tb_lb_regfile.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lb_pkg.sv
// Shared definitions for the local-bus register file: register indices,
// unmapped-read value and read-FSM state encoding.
package lb_pkg;

    localparam logic [2:0] IDX_ID      = 3'd0;
    localparam logic [2:0] IDX_SCRATCH = 3'd1;
    localparam logic [2:0] IDX_CTRL    = 3'd2;
    localparam logic [2:0] IDX_STATUS  = 3'd3;
    localparam logic [2:0] IDX_CYCLE   = 3'd4;
    localparam logic [2:0] IDX_USER5   = 3'd5;
    localparam logic [2:0] IDX_USER6   = 3'd6;
    localparam logic [2:0] IDX_USER7   = 3'd7;

    localparam logic [31:0] UNMAPPED_DATA = 32'hDEAD_BEEF;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } rd_state_e;

endpackage

// File: rtl/lb_rd_delay.sv
// Read-latency FSM: samples read data on an accepted request and presents it
// with a one-cycle finish pulse C_RD_LATENCY cycles later.
module lb_rd_delay
    import lb_pkg::*;
#(
    parameter int C_DATA_WIDTH = 32,
    parameter int C_RD_LATENCY = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    rreq_i,
    input  logic [C_DATA_WIDTH-1:0] data_i,
    output logic                    rfinish_o,
    output logic [C_DATA_WIDTH-1:0] rdata_o,
    output logic                    overrun_o
);

    localparam logic [3:0] LOAD_CNT = 4'(C_RD_LATENCY - 1);

    rd_state_e                state_q, state_d;
    logic [3:0]               cnt_q, cnt_d;
    logic [C_DATA_WIDTH-1:0]  hold_q, hold_d;
    logic [C_DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic                     rfinish_q, rfinish_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hold_d    = hold_q;
        rdata_d   = rdata_q;
        rfinish_d = 1'b0;
        overrun_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rreq_i) begin
                    // A single-cycle latency never needs the WAIT state.
                    if (C_RD_LATENCY == 1) begin
                        rfinish_d = 1'b1;
                        rdata_d   = data_i;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = LOAD_CNT;
                        hold_d  = data_i;
                    end
                end
            end
            ST_WAIT: begin
                overrun_o = rreq_i;
                if (cnt_q == 4'd1) begin
                    rfinish_d = 1'b1;
                    rdata_d   = hold_q;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hold_q    <= '0;
            rdata_q   <= '0;
            rfinish_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            rdata_q   <= rdata_d;
            rfinish_q <= rfinish_d;
        end
    end

    assign rfinish_o = rfinish_q;
    assign rdata_o   = rdata_q;

endmodule

// File: rtl/lb_regfile.sv
// Local-bus slave with eight 32-bit registers: ID, scratch, control, sticky
// status, free-running cycle counter and three user registers.
module lb_regfile
    import lb_pkg::*;
#(
    parameter int                      C_ADDR_WIDTH = 16,
    parameter int                      C_DATA_WIDTH = 32,
    parameter logic [C_ADDR_WIDTH-1:0] C_BASE_ADDR  = '0,
    parameter int                      C_RD_LATENCY = 2,
    parameter logic [31:0]             C_ID         = 32'h4C42_5246
) (
    input  logic                    LB_CLK_I,
    input  logic                    LB_RSTN_I,
    input  logic [C_ADDR_WIDTH-1:0] LB_WADDR_I,
    input  logic [C_DATA_WIDTH-1:0] LB_WDATA_I,
    input  logic                    LB_WREQ_I,
    input  logic [C_ADDR_WIDTH-1:0] LB_RADDR_I,
    input  logic                    LB_RREQ_I,
    output logic [C_DATA_WIDTH-1:0] LB_RDATA_O,
    output logic                    LB_RFINISH_O,
    input  logic [15:0]             STATUS_SET_I,
    output logic [31:0]             CTRL_O,
    output logic [95:0]             USER_O,
    output logic                    IRQ_O
);

    logic [C_ADDR_WIDTH-1:0] widx, ridx;
    logic                    wr_hit, rd_hit, wr_status, overrun;
    logic [2:0]              wsel, rsel;
    logic [15:0]             status_clr;
    logic [C_DATA_WIDTH-1:0] rd_mux;

    logic [C_DATA_WIDTH-1:0] scratch_q, scratch_d, ctrl_q, ctrl_d, cycle_q, cycle_d;
    logic [C_DATA_WIDTH-1:0] user5_q, user5_d, user6_q, user6_d, user7_q, user7_d;
    logic [15:0]             status_q, status_d;
    logic                    ovr_q, ovr_d, irq_q, irq_d;

    // Unsigned wrap makes addresses below the base land far outside the window.
    assign widx   = LB_WADDR_I - C_BASE_ADDR;
    assign ridx   = LB_RADDR_I - C_BASE_ADDR;
    assign wsel   = widx[2:0];
    assign rsel   = ridx[2:0];
    assign wr_hit = LB_WREQ_I && (widx[C_ADDR_WIDTH-1:3] == '0);
    assign rd_hit = (ridx[C_ADDR_WIDTH-1:3] == '0);

    assign wr_status  = wr_hit && (wsel == IDX_STATUS);
    assign status_clr = wr_status ? LB_WDATA_I[15:0] : 16'h0000;

    always_comb begin
        scratch_d = scratch_q;
        ctrl_d    = ctrl_q;
        user5_d   = user5_q;
        user6_d   = user6_q;
        user7_d   = user7_q;
        if (wr_hit) begin
            case (wsel)
                IDX_SCRATCH: scratch_d = LB_WDATA_I;
                IDX_CTRL:    ctrl_d    = LB_WDATA_I;
                IDX_USER5:   user5_d   = LB_WDATA_I;
                IDX_USER6:   user6_d   = LB_WDATA_I;
                IDX_USER7:   user7_d   = LB_WDATA_I;
                default:     ;
            endcase
        end
        cycle_d  = (wr_hit && (wsel == IDX_CYCLE)) ? '0 : cycle_q + 1'b1;
        // New set pulses are OR-ed in after the clear so a set always wins.
        status_d = STATUS_SET_I | (status_q & ~status_clr);
        ovr_d    = overrun | (ovr_q & ~(wr_status & LB_WDATA_I[31]));
        irq_d    = |(status_q & ctrl_q[15:0]);
    end

    always_comb begin
        rd_mux = UNMAPPED_DATA;
        if (rd_hit) begin
            case (rsel)
                IDX_ID:      rd_mux = C_ID;
                IDX_SCRATCH: rd_mux = scratch_q;
                IDX_CTRL:    rd_mux = ctrl_q;
                IDX_STATUS:  rd_mux = {ovr_q, 15'h0000, status_q};
                IDX_CYCLE:   rd_mux = cycle_q;
                IDX_USER5:   rd_mux = user5_q;
                IDX_USER6:   rd_mux = user6_q;
                IDX_USER7:   rd_mux = user7_q;
                default:     rd_mux = UNMAPPED_DATA;
            endcase
        end
    end

    always_ff @(posedge LB_CLK_I or negedge LB_RSTN_I) begin
        if (!LB_RSTN_I) begin
            scratch_q <= '0;
            ctrl_q    <= '0;
            cycle_q   <= '0;
            user5_q   <= '0;
            user6_q   <= '0;
            user7_q   <= '0;
            status_q  <= '0;
            ovr_q     <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            scratch_q <= scratch_d;
            ctrl_q    <= ctrl_d;
            cycle_q   <= cycle_d;
            user5_q   <= user5_d;
            user6_q   <= user6_d;
            user7_q   <= user7_d;
            status_q  <= status_d;
            ovr_q     <= ovr_d;
            irq_q     <= irq_d;
        end
    end

    lb_rd_delay #(
        .C_DATA_WIDTH (C_DATA_WIDTH),
        .C_RD_LATENCY (C_RD_LATENCY)
    ) u_rd_delay (
        .clk_i     (LB_CLK_I),
        .rst_ni    (LB_RSTN_I),
        .rreq_i    (LB_RREQ_I),
        .data_i    (rd_mux),
        .rfinish_o (LB_RFINISH_O),
        .rdata_o   (LB_RDATA_O),
        .overrun_o (overrun)
    );

    assign CTRL_O = ctrl_q;
    assign USER_O = {user7_q, user6_q, user5_q};
    assign IRQ_O  = irq_q;

endmodule

// File: tb/tb_lb_regfile.sv
// Scoreboard bench for lb_regfile: reads push expected data and finish cycle,
// the finish monitor pops and compares them.
module tb_lb_regfile;

    localparam int          LAT  = 2;
    localparam logic [31:0] ID_V = 32'h4C42_5246;
    localparam logic [31:0] BEEF = 32'hDEAD_BEEF;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } rd_item_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic [15:0] LB_WADDR_I = '0;
    logic [31:0] LB_WDATA_I = '0;
    logic        LB_WREQ_I = 1'b0;
    logic [15:0] LB_RADDR_I = '0;
    logic        LB_RREQ_I = 1'b0;
    logic [31:0] LB_RDATA_O;
    logic        LB_RFINISH_O;
    logic [15:0] STATUS_SET_I = '0;
    logic [31:0] CTRL_O;
    logic [95:0] USER_O;
    logic        IRQ_O;

    int       checks = 0;
    int       errors = 0;
    int       cyc = 0;
    rd_item_t sb[$];
    rd_item_t mon_item;

    lb_regfile #(
        .C_ADDR_WIDTH (16),
        .C_DATA_WIDTH (32),
        .C_BASE_ADDR  (16'h0000),
        .C_RD_LATENCY (LAT),
        .C_ID         (ID_V)
    ) dut (
        .LB_CLK_I     (clk),
        .LB_RSTN_I    (rstn),
        .LB_WADDR_I   (LB_WADDR_I),
        .LB_WDATA_I   (LB_WDATA_I),
        .LB_WREQ_I    (LB_WREQ_I),
        .LB_RADDR_I   (LB_RADDR_I),
        .LB_RREQ_I    (LB_RREQ_I),
        .LB_RDATA_O   (LB_RDATA_O),
        .LB_RFINISH_O (LB_RFINISH_O),
        .STATUS_SET_I (STATUS_SET_I),
        .CTRL_O       (CTRL_O),
        .USER_O       (USER_O),
        .IRQ_O        (IRQ_O)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every finish pulse must match the oldest outstanding read exactly.
    always @(negedge clk) begin
        if (LB_RFINISH_O === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_rfinish at cycle %0d rdata=%08h required no finish", cyc, LB_RDATA_O);
            end else begin
                mon_item = sb.pop_front();
                checks++;
                if (cyc !== mon_item.cyc) begin
                    errors++;
                    $display("[TB] FAIL rd_latency finish cycle=%0d required=%0d", cyc, mon_item.cyc);
                end
                checks++;
                if (LB_RDATA_O !== mon_item.data) begin
                    errors++;
                    $display("[TB] FAIL rd_data got=%08h required=%08h", LB_RDATA_O, mon_item.data);
                end
            end
        end
    end

    task automatic do_write(input logic [15:0] a, input logic [31:0] d);
        LB_WADDR_I = a;
        LB_WDATA_I = d;
        LB_WREQ_I  = 1'b1;
        @(posedge clk); #1;
        LB_WREQ_I  = 1'b0;
    endtask

    task automatic do_read(input logic [15:0] a, input logic [31:0] exp);
        sb.push_back('{exp, cyc + LAT});
        LB_RADDR_I = a;
        LB_RREQ_I  = 1'b1;
        @(posedge clk); #1;
        LB_RREQ_I  = 1'b0;
    endtask

    task automatic wait_reads();
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL read_timeout outstanding=%0d required=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        #2 rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({LB_RFINISH_O, LB_RDATA_O, CTRL_O, USER_O, IRQ_O} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs rdata=%08h fin=%b ctrl=%08h user=%024h irq=%b required all 0",
                     LB_RDATA_O, LB_RFINISH_O, CTRL_O, USER_O, IRQ_O);
        end
        rstn = 1'b1;
        @(posedge clk); #1;
        do_read(16'h0003, 32'h0);
        wait_reads();
    endtask

    task automatic test_scratch();
        do_write(16'h0001, 32'h1122_3344);
        do_read(16'h0001, 32'h1122_3344);
        wait_reads();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (LB_RDATA_O !== 32'h1122_3344) begin
            errors++;
            $display("[TB] FAIL rdata_hold got=%08h required=%08h", LB_RDATA_O, 32'h1122_3344);
        end
    endtask

    task automatic test_id();
        do_read(16'h0000, ID_V);
        wait_reads();
        do_write(16'h0000, 32'h0);
        do_read(16'h0000, ID_V);
        wait_reads();
    endtask

    task automatic test_user_unmapped();
        do_write(16'h0005, 32'h5555_0005);
        do_write(16'h0006, 32'h6666_0006);
        do_write(16'h0007, 32'h7777_0007);
        checks++;
        if (USER_O !== 96'h7777_0007_6666_0006_5555_0005) begin
            errors++;
            $display("[TB] FAIL user_o got=%024h required=%024h", USER_O, 96'h7777_0007_6666_0006_5555_0005);
        end
        do_read(16'h0007, 32'h7777_0007);
        wait_reads();
        do_read(16'h8888, BEEF);
        wait_reads();
        do_write(16'h0008, 32'hFFFF_FFFF);
        do_read(16'h0008, BEEF);
        wait_reads();
        do_read(16'h0006, 32'h6666_0006);
        wait_reads();
    endtask

    task automatic test_overrun();
        do_read(16'h0001, 32'h1122_3344);
        LB_RADDR_I = 16'h0000;
        LB_RREQ_I  = 1'b1;
        @(posedge clk); #1;
        LB_RREQ_I  = 1'b0;
        wait_reads();
        do_read(16'h0003, 32'h8000_0000);
        wait_reads();
        do_write(16'h0003, 32'h8000_0000);
        do_read(16'h0003, 32'h0);
        wait_reads();
    endtask

    task automatic test_irq();
        do_write(16'h0002, 32'h0000_0004);
        checks++;
        if (CTRL_O !== 32'h0000_0004) begin
            errors++;
            $display("[TB] FAIL ctrl_o got=%08h required=%08h", CTRL_O, 32'h4);
        end
        STATUS_SET_I = 16'h0004;
        @(posedge clk); #1;
        STATUS_SET_I = 16'h0000;
        checks++;
        if (IRQ_O !== 1'b0) begin
            errors++;
            $display("[TB] FAIL irq_latency got=%b required=0", IRQ_O);
        end
        @(posedge clk); #1;
        checks++;
        if (IRQ_O !== 1'b1) begin
            errors++;
            $display("[TB] FAIL irq_assert got=%b required=1", IRQ_O);
        end
        LB_WADDR_I   = 16'h0003;
        LB_WDATA_I   = 32'h0000_0004;
        LB_WREQ_I    = 1'b1;
        STATUS_SET_I = 16'h0004;
        @(posedge clk); #1;
        LB_WREQ_I    = 1'b0;
        STATUS_SET_I = 16'h0000;
        do_read(16'h0003, 32'h0000_0004);
        wait_reads();
        do_write(16'h0003, 32'h0000_0004);
        do_read(16'h0003, 32'h0);
        wait_reads();
        checks++;
        if (IRQ_O !== 1'b0) begin
            errors++;
            $display("[TB] FAIL irq_clear got=%b required=0", IRQ_O);
        end
    endtask

    task automatic test_back_to_back();
        do_write(16'h0001, 32'hAAAA_5555);
        sb.push_back('{32'hAAAA_5555, cyc + LAT});
        LB_WADDR_I = 16'h0001;
        LB_WDATA_I = 32'h5A5A_A5A5;
        LB_WREQ_I  = 1'b1;
        LB_RADDR_I = 16'h0001;
        LB_RREQ_I  = 1'b1;
        @(posedge clk); #1;
        LB_WREQ_I  = 1'b0;
        LB_RREQ_I  = 1'b0;
        wait_reads();
        do_read(16'h0001, 32'h5A5A_A5A5);
        wait_reads();
    endtask

    task automatic test_cycle();
        int clr;
        do_write(16'h0004, 32'h0000_1234);
        clr = cyc;
        do_read(16'h0004, 32'(cyc - clr));
        wait_reads();
        repeat (5) @(posedge clk);
        #1;
        do_read(16'h0004, 32'(cyc - clr));
        wait_reads();
    endtask

    task automatic test_reset_mid_read();
        int clr;
        do_write(16'h0002, 32'hFFFF_0001);
        STATUS_SET_I = 16'h0001;
        @(posedge clk); #1;
        STATUS_SET_I = 16'h0000;
        do_read(16'h0001, 32'h5A5A_A5A5);
        wait_reads();
        do_read(16'h0002, 32'hFFFF_0001);
        rstn = 1'b0;
        sb.delete();
        #1;
        checks++;
        if ({LB_RFINISH_O, LB_RDATA_O, CTRL_O, USER_O, IRQ_O} !== '0) begin
            errors++;
            $display("[TB] FAIL midread_reset_outputs rdata=%08h fin=%b ctrl=%08h user=%024h irq=%b required all 0",
                     LB_RDATA_O, LB_RFINISH_O, CTRL_O, USER_O, IRQ_O);
        end
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        clr = cyc;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (LB_RDATA_O !== 32'h0) begin
            errors++;
            $display("[TB] FAIL rdata_after_abort got=%08h required=%08h", LB_RDATA_O, 32'h0);
        end
        do_read(16'h0004, 32'(cyc - clr));
        wait_reads();
        do_read(16'h0002, 32'h0);
        wait_reads();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout reached required finish earlier");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        test_reset();
        test_scratch();
        test_id();
        test_user_unmapped();
        test_overrun();
        test_irq();
        test_back_to_back();
        test_cycle();
        test_reset_mid_read();
        repeat (5) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
